// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the 32-bit sprite command bus.
// Word layout: [31:26] component, [25:21] child, [20:17] action,
// [16:14] action_type, [13] buffer_toggle, [12:0] action_data.
// Used by the transmit encoder and by the per-sprite display blocks.
package sprite_cmd_pkg;

  localparam int unsigned CMD_W     = 32;
  localparam int unsigned COMP_LSB  = 26;
  localparam int unsigned COMP_W    = 6;
  localparam int unsigned CHILD_LSB = 21;
  localparam int unsigned CHILD_W   = 5;
  localparam int unsigned ACT_LSB   = 17;
  localparam int unsigned ACT_W     = 4;
  localparam int unsigned TYP_LSB   = 14;
  localparam int unsigned TYP_W     = 3;
  localparam int unsigned TOG_BIT   = 13;
  localparam int unsigned DATA_W    = 13;

  localparam logic [3:0] ACT_UPDATE  = 4'b0001;
  localparam logic [3:0] ACT_FLIP    = 4'b1111;

  localparam logic [2:0] TYP_FLIP    = 3'b000;
  localparam logic [2:0] TYP_VISFLIP = 3'b001;
  localparam logic [2:0] TYP_X       = 3'b010;
  localparam logic [2:0] TYP_Y       = 3'b011;
  localparam logic [2:0] TYP_ATTR    = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPD,
    ST_FLIP
  } state_t;

  function automatic logic [CMD_W-1:0] pack_cmd(
    input logic [COMP_W-1:0]  comp,
    input logic [CHILD_W-1:0] child,
    input logic [ACT_W-1:0]   act,
    input logic [TYP_W-1:0]   typ,
    input logic               tog,
    input logic [DATA_W-1:0]  data
  );
    logic [CMD_W-1:0] w;
    w = '0;
    w[COMP_LSB  +: COMP_W]  = comp;
    w[CHILD_LSB +: CHILD_W] = child;
    w[ACT_LSB   +: ACT_W]   = act;
    w[TYP_LSB   +: TYP_W]   = typ;
    w[TOG_BIT]              = tog;
    w[0         +: DATA_W]  = data;
    return w;
  endfunction

endpackage

// File: rtl/sprite_cmd_encoder.sv
// Transmit-side sprite command encoder.
// Serialises sprite update requests (4 words) and frame-flip requests
// (one word per enabled component) onto a valid/ready command stream,
// and owns the front/back buffer bit.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_*                 update request (valid/ready + fields)
//   flip_valid/ready      buffer-swap request, comp_mask sampled at accept
//   cmd_valid/ready/data  outbound command word stream (registered)
//   front_buf             currently displayed buffer
//   busy                  high whenever a sequence is in progress
module sprite_cmd_encoder #(
  parameter int unsigned NUM_COMP = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [5:0]          req_component,
  input  logic [4:0]          req_child,
  input  logic                req_visible,
  input  logic                req_flip,
  input  logic [9:0]          req_x,
  input  logic [9:0]          req_y,
  input  logic [9:0]          req_attr,
  input  logic                flip_valid,
  output logic                flip_ready,
  input  logic [NUM_COMP-1:0] comp_mask,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [31:0]         cmd_data,
  output logic                front_buf,
  output logic                busy
);
  import sprite_cmd_pkg::*;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_beat, w_beat_nxt;
  logic [5:0]  r_comp_cnt, w_cnt_nxt, w_cnt_inc;
  logic [63:0] r_mask, w_mask_nxt, w_mask_ext;
  logic        r_cmd_valid, w_valid_nxt;
  logic [31:0] r_cmd_data, w_data_nxt;
  logic        r_front_buf, w_front_nxt;
  logic        w_capture;

  logic [5:0]  r_comp;
  logic [4:0]  r_child;
  logic        r_visible, r_hflip;
  logic [9:0]  r_x, r_y, r_attr;

  function automatic logic [31:0] upd_word(
    input logic [1:0] beat,
    input logic [5:0] comp,
    input logic [4:0] child,
    input logic       vis,
    input logic       hfl,
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [9:0] attr,
    input logic       tog
  );
    logic [2:0]  typ;
    logic [12:0] data;
    case (beat)
      2'd0:    begin typ = TYP_VISFLIP; data = {vis, hfl, 11'b0}; end
      2'd1:    begin typ = TYP_X;       data = {3'b0, x};         end
      2'd2:    begin typ = TYP_Y;       data = {3'b0, y};         end
      default: begin typ = TYP_ATTR;    data = {3'b0, attr};      end
    endcase
    return pack_cmd(comp, child, ACT_UPDATE, typ, tog, data);
  endfunction

  assign flip_ready = (r_state == ST_IDLE);
  assign req_ready  = (r_state == ST_IDLE) && !flip_valid;
  assign w_capture  = req_ready && req_valid;
  assign w_cnt_inc  = r_comp_cnt + 6'd1;
  assign cmd_valid  = r_cmd_valid;
  assign cmd_data   = r_cmd_data;
  assign front_buf  = r_front_buf;
  assign busy       = (r_state != ST_IDLE);

  // The output register is loaded with the next word in the same edge
  // that accepts the previous one, so a held-high cmd_ready sees no gaps.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_cnt_nxt   = r_comp_cnt;
    w_mask_nxt  = r_mask;
    w_valid_nxt = r_cmd_valid;
    w_data_nxt  = r_cmd_data;
    w_front_nxt = r_front_buf;
    w_mask_ext  = '0;
    w_mask_ext[NUM_COMP-1:0] = comp_mask;
    case (r_state)
      ST_IDLE: begin
        if (flip_valid) begin
          w_state_nxt = ST_FLIP;
          w_cnt_nxt   = '0;
          w_mask_nxt  = w_mask_ext;
          w_valid_nxt = w_mask_ext[0];
          w_data_nxt  = pack_cmd(6'd0, 5'd0, ACT_FLIP, TYP_FLIP, ~r_front_buf, 13'd0);
        end else if (req_valid) begin
          w_state_nxt = ST_UPD;
          w_beat_nxt  = '0;
          w_valid_nxt = 1'b1;
          w_data_nxt  = upd_word(2'd0, req_component, req_child, req_visible,
                                 req_flip, req_x, req_y, req_attr, ~r_front_buf);
        end
      end
      ST_UPD: begin
        if (r_cmd_valid && cmd_ready) begin
          if (r_beat == 2'd3) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
          end else begin
            w_beat_nxt  = r_beat + 2'd1;
            w_data_nxt  = upd_word(r_beat + 2'd1, r_comp, r_child, r_visible,
                                   r_hflip, r_x, r_y, r_attr, ~r_front_buf);
          end
        end
      end
      ST_FLIP: begin
        // A masked slot has cmd_valid low and completes unconditionally.
        if (!r_cmd_valid || cmd_ready) begin
          if (r_comp_cnt == 6'(NUM_COMP - 1)) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_front_nxt = ~r_front_buf;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
            w_valid_nxt = r_mask[w_cnt_inc];
            w_data_nxt  = pack_cmd(w_cnt_inc, 5'd0, ACT_FLIP, TYP_FLIP, ~r_front_buf, 13'd0);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_comp_cnt  <= '0;
      r_mask      <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_data  <= '0;
      r_front_buf <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_comp_cnt  <= w_cnt_nxt;
      r_mask      <= w_mask_nxt;
      r_cmd_valid <= w_valid_nxt;
      r_cmd_data  <= w_data_nxt;
      r_front_buf <= w_front_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_comp    <= req_component;
      r_child   <= req_child;
      r_visible <= req_visible;
      r_hflip   <= req_flip;
      r_x       <= req_x;
      r_y       <= req_y;
      r_attr    <= req_attr;
    end
  end

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
module tb_sprite_cmd_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_component;
  logic [4:0]  req_child;
  logic        req_visible;
  logic        req_flip;
  logic [9:0]  req_x, req_y, req_attr;
  logic        flip_valid;
  logic        flip_ready;
  logic [15:0] comp_mask;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        front_buf;
  logic        busy;

  sprite_cmd_encoder #(.NUM_COMP(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_component(req_component), .req_child(req_child),
    .req_visible(req_visible), .req_flip(req_flip),
    .req_x(req_x), .req_y(req_y), .req_attr(req_attr),
    .flip_valid(flip_valid), .flip_ready(flip_ready), .comp_mask(comp_mask),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .front_buf(front_buf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected words are written for front_buf=0 (buffer_toggle=1).
  typedef struct packed {
    logic [5:0]  comp;
    logic [4:0]  child;
    logic        vis;
    logic        hfl;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  attr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
  } vec_t;

  vec_t tbl [3];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic front_exp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] tg(input logic [31:0] w);
    return front_exp ? (w ^ 32'h0000_2000) : w;
  endfunction

  task automatic drive_req(input vec_t v);
    req_component = v.comp;
    req_child     = v.child;
    req_visible   = v.vis;
    req_flip      = v.hfl;
    req_x         = v.x;
    req_y         = v.y;
    req_attr      = v.attr;
    req_valid     = 1'b1;
  endtask

  // Called with the request accepted at the preceding posedge.
  task automatic upd_words(input vec_t v, input bit stall);
    logic [31:0] w [4];
    w[0] = tg(v.w0); w[1] = tg(v.w1); w[2] = tg(v.w2); w[3] = tg(v.w3);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("upd_valid_b%0d", b), cmd_valid, 1);
      chk($sformatf("upd_data_b%0d", b), cmd_data, w[b]);
      chk($sformatf("upd_busy_b%0d", b), busy, 1);
      if (b == 1 && stall) begin
        cmd_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk($sformatf("stall_valid_%0d", s), cmd_valid, 1);
          chk($sformatf("stall_data_%0d", s), cmd_data, w[1]);
        end
        cmd_ready = 1'b1;
      end
    end
    @(negedge clk);
    chk("upd_end_valid", cmd_valid, 0);
    chk("upd_end_req_ready", req_ready, 1);
    chk("upd_end_busy", busy, 0);
  endtask

  task automatic do_update(input vec_t v, input bit stall);
    @(negedge clk);
    chk("upd_req_ready", req_ready, 1);
    drive_req(v);
    upd_words(v, stall);
  endtask

  task automatic flip_run(input logic [15:0] mask, input bit with_req, input vec_t v);
    logic [31:0] exp;
    @(negedge clk);
    flip_valid = 1'b1;
    comp_mask  = mask;
    if (with_req) drive_req(v);
    #1;
    chk("flip_ready", flip_ready, 1);
    if (with_req) chk("sim_req_ready", req_ready, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      flip_valid = 1'b0;
      comp_mask  = 16'hFFFF;  // must be ignored after accept
      chk($sformatf("flip_busy_s%0d", i), busy, 1);
      chk($sformatf("flip_valid_s%0d", i), cmd_valid, mask[i]);
      if (with_req) chk($sformatf("flip_req_ready_s%0d", i), req_ready, 0);
      if (mask[i]) begin
        exp = {6'(i), 5'b0, 4'hF, 3'b000, ~front_exp, 13'b0};
        chk($sformatf("flip_data_s%0d", i), cmd_data, exp);
      end
    end
    @(negedge clk);
    comp_mask = '0;
    front_exp = ~front_exp;
    chk("flip_end_busy", busy, 0);
    chk("flip_end_valid", cmd_valid, 0);
    chk("flip_end_front", front_buf, front_exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{comp: 6'd9, child: 5'd0, vis: 1'b1, hfl: 1'b0,
               x: 10'd100, y: 10'd200, attr: 10'd0,
               w0: 32'h2402_7000, w1: 32'h2402_A064, w2: 32'h2402_E0C8, w3: 32'h2403_2000};
    tbl[1] = '{comp: 6'd63, child: 5'd31, vis: 1'b0, hfl: 1'b1,
               x: 10'd1023, y: 10'd1023, attr: 10'd1023,
               w0: 32'hFFE2_6800, w1: 32'hFFE2_A3FF, w2: 32'hFFE2_E3FF, w3: 32'hFFE3_23FF};
    tbl[2] = '{comp: 6'd0, child: 5'd5, vis: 1'b1, hfl: 1'b1,
               x: 10'd1, y: 10'd512, attr: 10'h155,
               w0: 32'h00A2_7800, w1: 32'h00A2_A001, w2: 32'h00A2_E200, w3: 32'h00A3_2155};

    reset = 1'b1; req_valid = 1'b0; flip_valid = 1'b0; comp_mask = '0; cmd_ready = 1'b1;
    req_component = '0; req_child = '0; req_visible = 1'b0; req_flip = 1'b0;
    req_x = '0; req_y = '0; req_attr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_data", cmd_data, 0);
    chk("rst_front", front_buf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_flip_ready", flip_ready, 1);

    for (int i = 0; i < 3; i++) do_update(tbl[i], 1'b0);

    // Single-component flip, then an update lands in the new back buffer.
    flip_run(16'h0200, 1'b0, tbl[0]);
    @(negedge clk);
    drive_req(tbl[0]);
    @(negedge clk);
    req_valid = 1'b0;
    chk("post_flip_w0", cmd_data, 32'h2402_5000);
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("post_flip_idle", busy, 0);

    // Empty mask: 16 silent slots, buffer still swaps.
    flip_run(16'h0000, 1'b0, tbl[0]);

    // Backpressure on beat1.
    do_update(tbl[0], 1'b1);

    // Simultaneous requests: flip first, update afterwards with new toggle.
    flip_run(16'h0200, 1'b1, tbl[0]);
    chk("sim_after_req_ready", req_ready, 1);
    upd_words(tbl[0], 1'b0);

    // Reset during beat2 abandons the sequence.
    @(negedge clk);
    drive_req(tbl[0]);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_beat2_data", cmd_data, tg(tbl[0].w2));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_front", front_buf, 0);
    chk("mid_rst_busy", busy, 0);
    reset = 1'b0;
    front_exp = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    do_update(tbl[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_cmd_encoder.md
Name: sprite_cmd_encoder

Overview:
Transmit-side encoder for the 32-bit sprite command bus consumed by the per-sprite display blocks (ping/pong sprite state, per-component ID decode). It accepts sprite update requests and frame-flip requests from the game/control logic. It serialises them into the command word format and drives them out over a valid/ready stream. It owns the front/back buffer bit, so every update targets the back buffer and every flip swaps buffers coherently across all enabled components.

Parameters:
NUM_COMP, 16, number of component IDs swept by a flip (IDs 0..NUM_COMP-1, max 64)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  sprite update request valid
req_ready  out  1  update request accepted when req_valid && req_ready
req_component  in  6  target component ID
req_child  in  5  child component field, passed through
req_visible  in  1  sprite visible
req_flip  in  1  sprite horizontal flip
req_x  in  10  X position
req_y  in  10  Y position
req_attr  in  10  extra attributes
flip_valid  in  1  frame buffer-swap request
flip_ready  out  1  flip accepted when flip_valid && flip_ready
comp_mask  in  NUM_COMP  bit i set = send flip to component i; sampled at flip accept
cmd_valid  out  1  command word valid
cmd_ready  in  1  downstream accepts word when cmd_valid && cmd_ready
cmd_data  out  32  command word
front_buf  out  1  currently displayed buffer index
busy  out  1  high when not in IDLE

Behaviour:
- Word format: [31:26] component, [25:21] child, [20:17] action, [16:14] action_type, [13] buffer_toggle, [12:0] action_data.
- Reset values: cmd_valid=0, cmd_data=0, front_buf=0, busy=0. State is IDLE and all counters are 0.
- req_ready = (state==IDLE) && !flip_valid. flip_ready = (state==IDLE). A flip wins when both requests arrive in the same cycle.
- Every request field is registered at accept.
- Latency: accept at cycle T gives the first word with cmd_valid=1 at T+1.
- Stream rule: while cmd_valid && !cmd_ready, cmd_data is held stable and cmd_valid stays high. The block issues at most one word per cycle and never bubbles while cmd_ready is held high, except on masked flip slots.
- States:
  - IDLE: waits for an accept.
  - UPD: 4 beats, beat counter 0..3.
  - FLIP: component counter 0..NUM_COMP-1.
- UPD words all use action=4'b0001, component and child from the request, and buffer_toggle=~front_buf:
  - beat0: type 3'b001, data = {visible, flip, 11'b0}
  - beat1: type 3'b010, data = {3'b0, x}
  - beat2: type 3'b011, data = {3'b0, y}
  - beat3: type 3'b100, data = {3'b0, attr}
  - Acceptance of beat3 returns the block to IDLE on the next cycle.
- FLIP words use action=4'b1111, type=3'b000, child=0, data=0, buffer_toggle=~front_buf (the new front).
  - For counter i with the mask bit set: emit one word with component=i.
  - Mask bit clear: cmd_valid=0 for that cycle and the counter advances.
  - After slot NUM_COMP-1 completes, front_buf toggles in the same edge and the state returns to IDLE.
  - An all-zero mask takes NUM_COMP cycles, emits no words, and still toggles front_buf.
- front_buf changes only at flip completion. Updates accepted after a flip target the new back buffer.
- Reset mid-operation: the in-flight sequence is abandoned immediately and cmd_valid drops in the reset cycle's output. Partial sequences are not replayed.
- The block applies no range check on x/y. Bits pass through truncated to the field width.

Decomposition:
- Package sprite_cmd_pkg holds:
  - field position/width constants
  - action codes ACT_UPDATE=4'b0001 and ACT_FLIP=4'b1111
  - action_type codes TYP_VISFLIP=3'b001, TYP_X=3'b010, TYP_Y=3'b011, TYP_ATTR=3'b100
  - a state enum
  - a function pack_cmd(comp, child, act, typ, tog, data) returning the 32-bit word
- The display blocks share this package.
- No sub-module: a single FSM with an output register.

Test Plan:
- Update comp=9, child=0, vis=1, flip=0, x=100, y=200, attr=0, front=0, cmd_ready=1 -> words 0x24027000, 0x2402A064, 0x2402E0C8, 0x24032000 on consecutive cycles starting T+1; req_ready is high again after the last word.
- Flip with comp_mask=1<<9 only, NUM_COMP=16 -> single word 0x241E2000; front_buf becomes 1 after slot 15; a subsequent update to comp 9 carries bit13=0 (e.g. first word 0x24025000).
- Backpressure: cmd_ready low for 3 cycles during beat1 of the update -> 0x2402A064 is held stable for all stalled cycles; the sequence and final words are unchanged.
- Simultaneous flip_valid and req_valid in IDLE -> flip accepted and req_ready=0; the update is accepted only after the flip completes, using the toggled buffer bit.
- comp_mask=0 flip -> no cmd_valid for 16 cycles; front_buf toggles; busy is high for exactly 16 cycles.
- Reset asserted during beat2 -> cmd_valid=0 and front_buf=0 next cycle; state IDLE; req_ready=1 after reset deasserts.
